mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between a CPU fetch port (I) and a data port (D).
// Data takes priority over fetch until the fetch port has been passed over STARVE_LIMIT times.
module mem_arbiter #(
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 3,
    parameter int TIMEOUT      = 255
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_readdata,
    output logic              i_busywait,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_writedata,
    output logic [DATA_W-1:0] d_readdata,
    output logic              d_busywait,
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_writedata,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_busywait,
    output logic              bus_err
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [7:0]    TMO_LAST   = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SERVE_D = 3'd1,
        SERVE_I = 3'd2,
        RESP_D  = 3'd3,
        RESP_I  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       starve_cnt_q, starve_cnt_d;
    logic [7:0]          tmo_cnt_q, tmo_cnt_d;
    logic                m_read_q, m_read_d;
    logic                m_write_q, m_write_d;
    logic [ADDR_W-1:0]   m_address_q, m_address_d;
    logic [DATA_W-1:0]   m_writedata_q, m_writedata_d;
    logic [DATA_W-1:0]   i_readdata_q, i_readdata_d;
    logic [DATA_W-1:0]   d_readdata_q, d_readdata_d;
    logic                bus_err_q, bus_err_d;

    logic d_req;
    logic serving_d;
    logic still_wanted;

    assign d_req = d_read | d_write;

    always_comb begin
        state_d       = state_q;
        starve_cnt_d  = starve_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        m_read_d      = m_read_q;
        m_write_d     = m_write_q;
        m_address_d   = m_address_q;
        m_writedata_d = m_writedata_q;
        i_readdata_d  = i_readdata_q;
        d_readdata_d  = d_readdata_q;
        bus_err_d     = bus_err_q;
        serving_d     = (state_q == SERVE_D);
        // A requester that has gone away by completion time gets its data discarded.
        still_wanted  = serving_d ? d_req : i_read;

        case (state_q)
            IDLE: begin
                tmo_cnt_d = 8'd0;
                if (d_req && (!i_read || (starve_cnt_q < STARVE_MAX))) begin
                    state_d       = SERVE_D;
                    m_address_d   = d_address;
                    m_writedata_d = d_writedata;
                    m_write_d     = d_write;
                    m_read_d      = ~d_write;
                    if (!i_read) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != STARVE_MAX) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end else if (i_read) begin
                    state_d      = SERVE_I;
                    m_address_d  = i_address;
                    m_read_d     = 1'b1;
                    m_write_d    = 1'b0;
                    starve_cnt_d = '0;
                end
            end
            SERVE_D, SERVE_I: begin
                tmo_cnt_d = tmo_cnt_q + 8'd1;
                if ((tmo_cnt_q != 8'd0) && !m_busywait) begin
                    m_read_d  = 1'b0;
                    m_write_d = 1'b0;
                    state_d   = serving_d ? RESP_D : RESP_I;
                    if (m_read_q && still_wanted) begin
                        if (serving_d) d_readdata_d = m_readdata;
                        else           i_readdata_d = m_readdata;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    m_read_d  = 1'b0;
                    m_write_d = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = serving_d ? RESP_D : RESP_I;
                    if (serving_d) d_readdata_d = '0;
                    else           i_readdata_d = '0;
                end
            end
            RESP_D, RESP_I: state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= IDLE;
            starve_cnt_q  <= '0;
            tmo_cnt_q     <= 8'd0;
            m_read_q      <= 1'b0;
            m_write_q     <= 1'b0;
            m_address_q   <= '0;
            m_writedata_q <= '0;
            i_readdata_q  <= '0;
            d_readdata_q  <= '0;
            bus_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            starve_cnt_q  <= starve_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            m_read_q      <= m_read_d;
            m_write_q     <= m_write_d;
            m_address_q   <= m_address_d;
            m_writedata_q <= m_writedata_d;
            i_readdata_q  <= i_readdata_d;
            d_readdata_q  <= d_readdata_d;
            bus_err_q     <= bus_err_d;
        end
    end

    assign i_busywait  = i_read & (state_q != RESP_I);
    assign d_busywait  = d_req & (state_q != RESP_D);
    assign m_read      = m_read_q;
    assign m_write     = m_write_q;
    assign m_address   = m_address_q;
    assign m_writedata = m_writedata_q;
    assign i_readdata  = i_readdata_q;
    assign d_readdata  = d_readdata_q;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions plus
// hand-written sequences for priority, starvation, withdrawal, timeout and reset.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_read = 1'b0;
    logic [5:0]  i_address = '0;
    logic [31:0] i_readdata;
    logic        i_busywait;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [5:0]  d_address = '0;
    logic [31:0] d_writedata = '0;
    logic [31:0] d_readdata;
    logic        d_busywait;
    logic        m_read, m_write;
    logic [5:0]  m_address;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;
    logic        m_busywait;
    logic        bus_err;

    mem_arbiter dut (
        .CLK(clk), .RESET(rst),
        .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
        .d_readdata(d_readdata), .d_busywait(d_busywait),
        .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_writedata(m_writedata),
        .m_readdata(m_readdata), .m_busywait(m_busywait), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Memory model: busy for 'lat' cycles of an access, or forever when 'stuck'.
    logic [31:0] mem [64];
    int  lat = 0;
    bit  stuck = 1'b0;
    bit  mem_clear = 1'b0;
    int  bcnt = 0;
    int  rd_cyc = 0;
    int  wr_cyc = 0;

    assign m_busywait = stuck || ((m_read || m_write) && (bcnt < lat));
    assign m_readdata = mem[m_address];

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int k = 0; k < 64; k++) mem[k] <= 32'h0001_0001 * k;
            mem[5] <= 32'h0002_0009;
        end else if ((m_read || m_write) && !m_busywait && m_write) begin
            mem[m_address] <= m_writedata;
        end
        if (m_read || m_write) bcnt <= bcnt + 1;
        else                   bcnt <= 0;
        if (m_read)  rd_cyc <= rd_cyc + 1;
        if (m_write) wr_cyc <= wr_cyc + 1;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          is_d;
        bit          rd;
        bit          we;
        logic [5:0]  addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp_rd;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[8];

    // Issue one request from IDLE, wait for its response, drop it, return in IDLE.
    task automatic run_txn(input vec_t v, output logic [31:0] rd, output int cyc,
                           output bit other_seen, output int strobes);
        int r0, w0;
        r0 = rd_cyc;
        w0 = wr_cyc;
        lat = v.lat;
        if (v.is_d) begin
            d_address = v.addr; d_writedata = v.wdata; d_write = v.we; d_read = v.rd;
        end else begin
            i_address = v.addr; i_read = 1'b1;
        end
        cyc = -1;
        other_seen = 1'b0;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            if (v.is_d ? i_busywait : d_busywait) other_seen = 1'b1;
            if (!(v.is_d ? d_busywait : i_busywait)) begin
                cyc = k;
                break;
            end
        end
        rd = v.is_d ? d_readdata : i_readdata;
        strobes = (rd_cyc - r0) + (wr_cyc - w0);
        d_read = 1'b0; d_write = 1'b0; i_read = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int cyc, strobes, dcyc, icyc, d_before, d_after, r0;
        bit other, i_done;
        vec_t v;

        //            is_d rd we addr   wdata          lat exp_rd         cyc
        vecs[0] = '{1'b0, 1'b0, 1'b0, 6'd5,  32'h0,         2, 32'h0002_0009, 4};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 6'd7,  32'hA5A5_0001, 0, 32'h0000_0000, 3};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 6'd7,  32'h0,         1, 32'hA5A5_0001, 3};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 6'd9,  32'h0,         3, 32'h0009_0009, 5};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 6'd63, 32'h0,         0, 32'h003F_003F, 3};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 6'd2,  32'h1234_5678, 1, 32'h003F_003F, 3};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 6'd2,  32'h0,         2, 32'h1234_5678, 4};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 6'd2,  32'h0,         0, 32'h1234_5678, 3};

        // Power-on reset
        rst = 1'b1; mem_clear = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst = 1'b0; mem_clear = 1'b0;
        chk("reset m_read", 32'(m_read), 32'h0);
        chk("reset m_write", 32'(m_write), 32'h0);
        chk("reset bus_err", 32'(bus_err), 32'h0);
        chk("reset i_readdata", i_readdata, 32'h0);
        chk("reset d_readdata", d_readdata, 32'h0);
        chk("reset m_address", 32'(m_address), 32'h0);

        // Single transactions from the table
        for (int n = 0; n < 8; n++) begin
            v = vecs[n];
            run_txn(v, rd, cyc, other, strobes);
            chk($sformatf("vec%0d latency", n), cyc, v.exp_cyc);
            chk($sformatf("vec%0d readdata", n), rd, v.exp_rd);
            chk($sformatf("vec%0d strobe cycles", n), strobes, v.exp_cyc - 1);
            chk($sformatf("vec%0d other busywait", n), 32'(other), 32'h0);
        end

        // Simultaneous write and fetch: write goes first
        lat = 0;
        i_read = 1'b1; i_address = 6'd4;
        d_write = 1'b1; d_address = 6'd3; d_writedata = 32'hDEAD_BEEF;
        dcyc = -1; icyc = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (!d_busywait && dcyc < 0) begin
                dcyc = k;
                d_write = 1'b0;
            end
            if (!i_busywait) begin
                icyc = k;
                break;
            end
        end
        i_read = 1'b0;
        @(negedge clk);
        chk("simul d response cycle", dcyc, 3);
        chk("simul i response cycle", icyc, 7);
        chk("simul mem[3]", mem[3], 32'hDEAD_BEEF);
        chk("simul i_readdata", i_readdata, 32'h0004_0004);

        // Starvation: three D grants, then I, then D again
        lat = 0;
        d_read = 1'b1; d_address = 6'd10;
        i_read = 1'b1; i_address = 6'd11;
        d_before = 0; d_after = 0; i_done = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (!d_busywait) begin
                if (i_done) d_after++;
                else        d_before++;
            end
            if (i_read && !i_busywait) begin
                i_done = 1'b1;
                i_read = 1'b0;
                chk("starve cnt after I grant", 32'(dut.starve_cnt_q), 32'h0);
            end
            if (d_after == 1) break;
        end
        d_read = 1'b0;
        @(negedge clk);
        chk("starve D grants before I", d_before, 3);
        chk("starve I served", 32'(i_done), 32'h1);
        chk("starve D resumed", d_after, 1);
        chk("starve d_readdata", d_readdata, 32'h000A_000A);
        chk("starve i_readdata", i_readdata, 32'h000B_000B);

        // Withdrawn D read: access completes, data discarded, pending I served next
        lat = 2;
        r0 = rd_cyc;
        i_read = 1'b1; i_address = 6'd12;
        d_read = 1'b1; d_address = 6'd13;
        icyc = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 2) d_read = 1'b0;
            if (!i_busywait) begin
                icyc = k;
                break;
            end
        end
        strobes = rd_cyc - r0;
        i_read = 1'b0;
        @(negedge clk);
        chk("withdraw i response cycle", icyc, 9);
        chk("withdraw read strobe cycles", strobes, 6);
        chk("withdraw d_readdata kept", d_readdata, 32'h000A_000A);
        chk("withdraw i_readdata", i_readdata, 32'h000C_000C);

        // Timeout with memory stuck busy, then sticky bus_err
        stuck = 1'b1;
        v = '{1'b1, 1'b1, 1'b0, 6'd20, 32'h0, 0, 32'h0, 256};
        run_txn(v, rd, cyc, other, strobes);
        stuck = 1'b0;
        chk("timeout latency", cyc, 256);
        chk("timeout strobe cycles", strobes, 255);
        chk("timeout d_readdata", rd, 32'h0);
        chk("timeout bus_err", 32'(bus_err), 32'h1);
        v = '{1'b0, 1'b0, 1'b0, 6'd21, 32'h0, 1, 32'h0, 3};
        run_txn(v, rd, cyc, other, strobes);
        chk("post-timeout i_readdata", rd, 32'h0015_0015);
        chk("bus_err sticky 1", 32'(bus_err), 32'h1);
        v = '{1'b1, 1'b1, 1'b0, 6'd22, 32'h0, 1, 32'h0, 3};
        run_txn(v, rd, cyc, other, strobes);
        chk("post-timeout d_readdata", rd, 32'h0016_0016);
        chk("bus_err sticky 2", 32'(bus_err), 32'h1);

        // Reset for two edges in the middle of a D read
        lat = 2;
        d_read = 1'b1; d_address = 6'd30;
        @(negedge clk); @(negedge clk);
        chk("pre-reset m_read active", 32'(m_read), 32'h1);
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b0; d_read = 1'b0;
        chk("mid reset m_read", 32'(m_read), 32'h0);
        chk("mid reset m_write", 32'(m_write), 32'h0);
        chk("mid reset bus_err", 32'(bus_err), 32'h0);
        chk("mid reset i_readdata", i_readdata, 32'h0);
        chk("mid reset d_readdata", d_readdata, 32'h0);
        chk("mid reset state", 32'(dut.state_q), 32'h0);
        @(negedge clk); @(negedge clk);
        chk("after reset idle m_read", 32'(m_read), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
